// File: rtl/fir_pkg.sv
//==============================================================================
// Module : fir_pkg
// Brief  : Shared types, state encoding and default sizes for the sequential FIR core.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package fir_pkg;

    localparam int DEF_N_TAPS = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_ACC_W  = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_N_TAPS);
    localparam int TAP_IDX_W  = $clog2(DEF_N_TAPS);

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fir_mac_unit.sv
//==============================================================================
// Module : fir_mac_unit
// Brief  : Registered signed multiply-accumulate; sum_o is the value the next enable stores.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int A_W   = DEF_COEF_W,
    parameter int B_W   = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [A_W+B_W-1:0] prod_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    always_comb begin
        prod_d = a_i * b_i;
        acc_d  = acc_q + {{(ACC_W-A_W-B_W){prod_d[A_W+B_W-1]}}, prod_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_d;

endmodule

`default_nettype wire

// File: rtl/fir_seq_mac_core.sv
//==============================================================================
// Module : fir_seq_mac_core
// Brief  : Time-multiplexed N-tap signed FIR: one shared MAC, one output per accepted sample.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fir_seq_mac_core
    import fir_pkg::*;
#(
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS)
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]    coef_wdata,
    output logic                        coef_wr_err,
    input  logic                        hist_clr,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [DATA_W-1:0]    s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [ACC_W-1:0]     m_data,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_TAPS);

    state_e                    state_q;
    logic [IDX_W-1:0]          tap_q;
    logic [IDX_W-1:0]          wr_ptr_q;
    logic signed [COEF_W-1:0]  coef_q [N_TAPS];
    logic signed [DATA_W-1:0]  hist_q [N_TAPS];
    logic signed [ACC_W-1:0]   m_data_q;
    logic                      m_valid_q;
    logic                      s_ready_q;
    logic                      busy_q;
    logic                      coef_wr_err_q;

    logic [IDX_W-1:0]          hist_idx_d;
    logic                      accept_d;
    logic signed [ACC_W-1:0]   acc_d;

    // Newest sample sits at wr_ptr; tap k reaches back k samples, wrapping mod N_TAPS.
    assign hist_idx_d = wr_ptr_q - tap_q;
    assign accept_d   = (state_q == IDLE) && s_valid;

    fir_mac_unit #(
        .A_W   (COEF_W),
        .B_W   (DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i (ACLK),
        .rst_i (ARESET),
        .clr_i (accept_d),
        .en_i  (state_q == MAC),
        .a_i   (coef_q[tap_q]),
        .b_i   (hist_q[hist_idx_d]),
        .sum_o (acc_d)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= IDLE;
            tap_q         <= '0;
            wr_ptr_q      <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            s_ready_q     <= 1'b1;
            busy_q        <= 1'b0;
            coef_wr_err_q <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            coef_wr_err_q <= 1'b0;
            if (coef_we) begin
                if (state_q == IDLE) begin
                    coef_q[coef_addr] <= coef_wdata;
                end else begin
                    coef_wr_err_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        hist_q[wr_ptr_q] <= s_data;
                        tap_q            <= '0;
                        state_q          <= MAC;
                        s_ready_q        <= 1'b0;
                        busy_q           <= 1'b1;
                    end else if (hist_clr) begin
                        for (int i = 0; i < N_TAPS; i++) begin
                            hist_q[i] <= '0;
                        end
                        wr_ptr_q <= '0;
                    end
                end
                MAC: begin
                    tap_q <= tap_q + IDX_W'(1);
                    // Last tap: capture the sum including this cycle's product.
                    if (tap_q == IDX_W'(N_TAPS - 1)) begin
                        m_data_q  <= acc_d;
                        wr_ptr_q  <= wr_ptr_q + IDX_W'(1);
                        state_q   <= OUT;
                        m_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign coef_wr_err = coef_wr_err_q;
    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire
